// File: rtl/mio_bus_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mio_bus_ctrl: decodes CPU memory-port accesses to block RAM, a GPIO register
// and a programmable down-counter, returning a one-cycle MIO_ready handshake.
// Rev 1.0
// ----------------------------------------------------------------------------
module mio_bus_ctrl #(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] GPIO_BASE = 32'hE000_0000,
    parameter logic [31:0] CNT_BASE  = 32'hF000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       Addr_in,
    input  logic [31:0]       Data_from_cpu,
    output logic [31:0]       Data_to_cpu,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [31:0]       gpio_out,
    output logic              counter_irq,
    output logic [1:0]        state_out
);

    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  ACCESS    = 2'd1;
    localparam logic [1:0]  WAIT      = 2'd2;
    localparam logic [1:0]  DONE      = 2'd3;
    localparam logic [31:0] CTRL_BASE = CNT_BASE + 32'd4;
    localparam logic [29:0] GPIO_WORD = GPIO_BASE[31:2];
    localparam logic [29:0] CNT_WORD  = CNT_BASE[31:2];
    localparam logic [29:0] CTRL_WORD = CTRL_BASE[31:2];

    logic [1:0]  state_q, state_d;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic [31:0] dout_q, dout_d;
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] cnt_q, cnt_d;
    logic        en_q, en_d;
    logic        irq_q, irq_d;

    logic        req_accept;
    logic        in_access;
    logic        hit_ram, hit_gpio, hit_cnt, hit_ctrl;
    logic        wr_access;
    logic        cnt_load, cnt_zero, cnt_dec;
    logic [31:0] periph_rdata;
    logic        unused_addr_lsb;

    // Byte-lane bits are not decoded; word accesses only.
    assign unused_addr_lsb = ^Addr_in[1:0];

    assign req_accept = (state_q == IDLE) && CPU_MIO;
    assign in_access  = (state_q == ACCESS);
    assign wr_access  = in_access && wr_q;

    assign hit_ram  = (addr_q[29:RAM_AW] == '0);
    assign hit_gpio = (addr_q == GPIO_WORD);
    assign hit_cnt  = (addr_q == CNT_WORD);
    assign hit_ctrl = (addr_q == CTRL_WORD);

    // ------------------------------------------------------------------
    // Request capture: the CPU holds its signals, but latching keeps the
    // access self-contained once accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (req_accept) begin
            addr_q  <= Addr_in[31:2];
            wdata_q <= Data_from_cpu;
            wr_q    <= mem_w;
        end
    end

    // ------------------------------------------------------------------
    // Bus FSM: state register, next-state logic, output logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (CPU_MIO) state_d = ACCESS;
            ACCESS:  state_d = (hit_ram && !wr_q) ? WAIT : DONE;
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MIO_ready = (state_q == DONE);
        ram_we    = wr_access && hit_ram;
        state_out = state_q;
    end

    assign ram_addr = addr_q[RAM_AW-1:0];
    assign ram_din  = wdata_q;

    // ------------------------------------------------------------------
    // Read data path: peripherals are captured in ACCESS, RAM in WAIT.
    // ------------------------------------------------------------------
    always_comb begin
        periph_rdata = 32'd0;
        if (hit_gpio) begin
            periph_rdata = {16'd0, sw_in};
        end else if (hit_cnt) begin
            periph_rdata = cnt_q;
        end else if (hit_ctrl) begin
            periph_rdata = {30'd0, cnt_zero, en_q};
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (in_access && !wr_q && !hit_ram) begin
            dout_d = periph_rdata;
        end else if (state_q == WAIT) begin
            dout_d = ram_dout;
        end
    end

    always_comb begin
        gpio_d = gpio_q;
        if (wr_access && hit_gpio) begin
            gpio_d = wdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Down-counter: free-running while enabled; a bus load always wins
    // over the decrement and suppresses the terminal-count pulse.
    // ------------------------------------------------------------------
    assign cnt_zero = (cnt_q == 32'd0);
    assign cnt_dec  = en_q && !cnt_zero;
    assign cnt_load = wr_access && hit_cnt;

    always_comb begin
        cnt_d = cnt_q;
        irq_d = 1'b0;
        if (cnt_load) begin
            cnt_d = wdata_q;
        end else if (cnt_dec) begin
            cnt_d = cnt_q - 32'd1;
            irq_d = (cnt_q == 32'd1);
        end
    end

    always_comb begin
        en_d = en_q;
        if (wr_access && hit_ctrl) begin
            en_d = wdata_q[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= '0;
            gpio_q <= '0;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            gpio_q <= gpio_d;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            irq_q  <= irq_d;
        end
    end

    assign Data_to_cpu = dout_q;
    assign gpio_out    = gpio_q;
    assign counter_irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mio_bus_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mio_bus_ctrl: directed and randomized bus accesses checked against a
// transaction-level model of RAM, GPIO and the down-counter.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mio_bus_ctrl;

    localparam int          RAM_AW = 10;
    localparam logic [31:0] GPIO_A = 32'hE000_0000;
    localparam logic [31:0] CNT_A  = 32'hF000_0000;
    localparam logic [31:0] CTRL_A = 32'hF000_0004;

    logic              clk           = 1'b0;
    logic              reset         = 1'b0;
    logic              CPU_MIO       = 1'b0;
    logic              mem_w         = 1'b0;
    logic [31:0]       Addr_in       = 32'd0;
    logic [31:0]       Data_from_cpu = 32'd0;
    logic [31:0]       Data_to_cpu;
    logic              MIO_ready;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [31:0]       ram_dout;
    logic [15:0]       sw_in         = 16'd0;
    logic [31:0]       gpio_out;
    logic              counter_irq;
    logic [1:0]        state_out;

    mio_bus_ctrl #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
        .Addr_in(Addr_in), .Data_from_cpu(Data_from_cpu), .Data_to_cpu(Data_to_cpu),
        .MIO_ready(MIO_ready), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .sw_in(sw_in), .gpio_out(gpio_out),
        .counter_irq(counter_irq), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous block RAM with a back-door preload port.
    logic [31:0] ram_mem [0:1023];
    logic        pl_we   = 1'b0;
    logic [9:0]  pl_addr = 10'd0;
    logic [31:0] pl_data = 32'd0;
    always @(posedge clk) begin
        if (pl_we) ram_mem[pl_addr] <= pl_data;
        else if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    int irq_seen[$];
    always @(negedge clk) if (counter_irq === 1'b1) irq_seen.push_back(cyc);

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [31:0] exp_ram [0:1023];
    logic [31:0] exp_gpio = 32'd0;
    logic [31:0] exp_dout = 32'd0;
    longint      m_val    = 0;
    longint      m_ref    = 0;
    bit          m_en     = 1'b0;
    int          exp_irq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counter value just after clock edge t, from the last (value, edge, enable) segment.
    function automatic longint cnt_at(input longint t);
        if (!m_en || m_val == 0) return m_val;
        if (t - m_ref >= m_val) return 0;
        return m_val - (t - m_ref);
    endfunction

    function automatic void model_flush(input longint lim);
        if (m_en && m_val > 0 && m_ref + m_val <= lim) begin
            exp_irq.push_back(int'(m_ref + m_val));
            m_val = 0;
        end
    endfunction

    function automatic void cnt_load(input longint x, input logic [31:0] v);
        if (m_en && m_val > 0 && m_ref + m_val < x) exp_irq.push_back(int'(m_ref + m_val));
        m_val = longint'(v);
        m_ref = x;
    endfunction

    function automatic void cnt_ctrl(input longint x, input bit e);
        model_flush(x);
        m_val = cnt_at(x);
        m_ref = x;
        m_en  = e;
    endfunction

    task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input bit hold);
        int          n, we_cnt, a, exp_lat;
        bit          rdy, is_ram;
        logic [29:0] word;
        logic [9:0]  wa;
        logic [31:0] wd;
        word   = addr[31:2];
        is_ram = (addr[31:12] == 20'd0);
        @(negedge clk);
        CPU_MIO = 1'b1; mem_w = we; Addr_in = addr; Data_from_cpu = data;
        @(posedge clk); #1;
        a = cyc;
        n = 0; rdy = 1'b0; we_cnt = 0; wa = '0; wd = '0;
        while (!rdy && n < 8) begin
            @(negedge clk);
            rdy = MIO_ready;
            if (ram_we) begin we_cnt++; wa = ram_addr; wd = ram_din; end
            @(posedge clk);
            n++;
        end
        #1;
        if (!hold) CPU_MIO = 1'b0;
        exp_lat = (is_ram && !we) ? 3 : 2;
        if (we) begin
            if (is_ram) exp_ram[word[9:0]] = data;
            else if (word == GPIO_A[31:2]) exp_gpio = data;
            else if (word == CNT_A[31:2]) cnt_load(a + 1, data);
            else if (word == CTRL_A[31:2]) cnt_ctrl(a + 1, data[0]);
        end else begin
            if (is_ram) exp_dout = exp_ram[word[9:0]];
            else if (word == GPIO_A[31:2]) exp_dout = {16'd0, sw_in};
            else if (word == CNT_A[31:2]) exp_dout = 32'(cnt_at(a));
            else if (word == CTRL_A[31:2]) exp_dout = {30'd0, cnt_at(a) == 0, m_en};
            else exp_dout = 32'd0;
        end
        chk("latency", n, exp_lat);
        chk("ready_one_cycle", {31'd0, MIO_ready}, 32'd0);
        chk("ram_we_cycles", we_cnt, (is_ram && we) ? 1 : 0);
        if (is_ram && we) begin
            chk("ram_addr", {22'd0, wa}, {22'd0, word[9:0]});
            chk("ram_din", wd, data);
        end
        chk("data_to_cpu", Data_to_cpu, exp_dout);
        chk("gpio_out", gpio_out, exp_gpio);
    endtask

    task automatic irq_check(input string tag);
        int lim;
        @(posedge clk); #1;
        lim = cyc - 1;
        model_flush(lim);
        chk({tag, "_count"}, irq_seen.size(), exp_irq.size());
        for (int i = 0; i < irq_seen.size() && i < exp_irq.size(); i++)
            chk(tag, irq_seen[i], exp_irq[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] unm [5];
        logic [31:0] ad, dt;
        logic [9:0]  wi;
        logic [1:0]  lo;
        int          k, a;
        bit          w, h, rdy_seen;
        unm = '{32'h0000_1000, 32'h8000_0000, 32'hE000_0004, 32'hF000_0008, 32'hFFFF_FFFC};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_to_cpu", Data_to_cpu, 32'd0);
        chk("rst_gpio", gpio_out, 32'd0);
        chk("rst_ready", {31'd0, MIO_ready}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_irq", {31'd0, counter_irq}, 32'd0);
        chk("rst_state", {30'd0, state_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // RAM write then read of a preloaded word
        do_op(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = 10'd4; pl_data = 32'h1234_5678;
        @(negedge clk);
        pl_we = 1'b0;
        exp_ram[4] = 32'h1234_5678;
        do_op(1'b0, 32'h0000_0010, 32'd0, 1'b0);

        // GPIO write and switch read
        do_op(1'b1, GPIO_A, 32'h0000_00A5, 1'b0);
        sw_in = 16'h5A5A;
        do_op(1'b0, GPIO_A, 32'd0, 1'b0);

        // Counter: load 3, enable, run to zero, read status
        do_op(1'b1, CNT_A, 32'd3, 1'b0);
        do_op(1'b1, CTRL_A, 32'd1, 1'b0);
        repeat (6) @(posedge clk);
        do_op(1'b0, CTRL_A, 32'd0, 1'b0);
        irq_check("irq_first");

        // Reload lands exactly on the 1->0 decrement, then load 0
        do_op(1'b1, CNT_A, 32'd3, 1'b1);
        do_op(1'b1, CNT_A, 32'd5, 1'b0);
        do_op(1'b0, CNT_A, 32'd0, 1'b0);
        repeat (8) @(posedge clk);
        do_op(1'b1, CNT_A, 32'd0, 1'b0);
        do_op(1'b0, CTRL_A, 32'd0, 1'b0);
        irq_check("irq_reload");

        // Unmapped reads
        do_op(1'b0, 32'h0000_1000, 32'd0, 1'b0);
        do_op(1'b0, 32'h8000_0000, 32'd0, 1'b0);
        do_op(1'b1, 32'h8000_0000, 32'h1111_1111, 1'b0);

        // Back-to-back with CPU_MIO held high
        do_op(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b1);
        do_op(1'b0, 32'h0000_0020, 32'd0, 1'b1);
        sw_in = 16'hA1B2;
        do_op(1'b0, GPIO_A, 32'd0, 1'b1);
        do_op(1'b0, 32'h0000_0010, 32'd0, 1'b0);

        // Reset during ACCESS of a GPIO write
        @(negedge clk);
        CPU_MIO = 1'b1; mem_w = 1'b1; Addr_in = GPIO_A; Data_from_cpu = 32'h0000_0077;
        @(posedge clk); #1;
        a = cyc;
        chk("mid_state_access", {30'd0, state_out}, 32'd1);
        #1 reset = 1'b0;
        #1;
        CPU_MIO = 1'b0;
        model_flush(a - 1);
        m_val = 0; m_en = 1'b0; exp_gpio = 32'd0; exp_dout = 32'd0;
        chk("mid_rst_state", {30'd0, state_out}, 32'd0);
        chk("mid_rst_gpio", gpio_out, 32'd0);
        chk("mid_rst_dout", Data_to_cpu, 32'd0);
        rdy_seen = 1'b0;
        repeat (2) @(negedge clk) if (MIO_ready) rdy_seen = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk) if (MIO_ready || gpio_out != 32'd0) rdy_seen = 1'b1;
        chk("mid_rst_no_ready", {31'd0, rdy_seen}, 32'd0);
        do_op(1'b1, GPIO_A, 32'h0000_0033, 1'b0);
        do_op(1'b0, CTRL_A, 32'd0, 1'b0);

        // Randomized phase over a preloaded RAM window
        for (int i = 0; i < 17; i++) begin
            wi = (i == 16) ? 10'd1023 : 10'(i);
            do_op(1'b1, {20'd0, wi, 2'b00}, $urandom, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            k  = int'($urandom_range(0, 5));
            w  = 1'($urandom_range(0, 1));
            h  = (i == 59) ? 1'b0 : 1'($urandom_range(0, 1));
            lo = 2'($urandom_range(0, 3));
            sw_in = 16'($urandom);
            case (k)
                0, 1: begin
                    wi = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
                    ad = {20'd0, wi, lo};
                end
                2:       ad = GPIO_A | 32'(lo);
                3:       ad = CNT_A | 32'(lo);
                4:       ad = CTRL_A | 32'(lo);
                default: ad = unm[$urandom_range(0, 4)] | 32'(lo);
            endcase
            dt = (k == 3) ? 32'($urandom_range(0, 12)) : $urandom;
            do_op(w, ad, dt, h);
        end
        repeat (4) @(posedge clk);
        irq_check("irq_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
